// File: rtl/flexbus_pkg.sv
// Shared FlexBus register-file definitions: FSM encoding and bus/index widths.
package flexbus_pkg;
  localparam int IDX_W  = 6;
  localparam int AD_W   = 32;
  localparam int WCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_HOLD = 3'd4
  } fb_state_t;
endpackage

// File: rtl/flexbus_reg_slice.sv
// One 32-bit control register with per-byte write enables and a registered write strobe.
module flexbus_reg_slice
  import flexbus_pkg::*;
#(
  parameter logic [AD_W-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      lane_en,
  input  logic [AD_W-1:0] wdata,
  output logic [AD_W-1:0] q,
  output logic            wstb
);

  always_ff @(posedge clk) begin
    if (rst) wstb <= 1'b0;
    else     wstb <= we;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)                    q[8*gi +: 8] <= RST_VAL[8*gi +: 8];
      else if (we && lane_en[gi]) q[8*gi +: 8] <= wdata[8*gi +: 8];
    end
  end

endmodule

// File: rtl/perip_flexbus_regfile.sv
// FlexBus slave register file: NREG R/W control regs, NSTAT read-only status regs, WAIT_CYC wait states.
// Define FLEXBUS_BE_EN to honour FB_BE byte enables on control-register writes.
module perip_flexbus_regfile
  import flexbus_pkg::*;
#(
  parameter logic [31:0] FB_BASE      = 32'h6000_0000,
  parameter logic [31:0] BASE_MASK    = 32'hF000_0000,
  parameter int          NREG         = 8,
  parameter int          NSTAT        = 2,
  parameter int          WAIT_CYC     = 0,
  parameter logic [31:0] REG_RST_VAL  = 32'h0,
  parameter logic [31:0] UNMAP_RD_VAL = 32'h0
) (
  input  logic                                  FB_CLK,
  input  logic                                  RST,
  input  logic                                  FB_ALE,
  input  logic                                  FB_CS,
  input  logic                                  FB_RW,
  input  logic [3:0]                            FB_BE,
  input  logic [AD_W-1:0]                       FB_AD_I,
  output logic [AD_W-1:0]                       FB_AD_O,
  output logic                                  FB_AD_OE,
  output logic                                  FB_TA,
  output logic [NREG*32-1:0]                    REG_Qout,
  output logic [NREG-1:0]                       REG_WSTB,
  input  logic [((NSTAT > 0) ? NSTAT : 1)*32-1:0] STAT_Din
);

  localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT_CYC > 0) ? WCNT_W'(WAIT_CYC - 1) : '0;

  fb_state_t         state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  idx_reg;
  logic              unmap_reg;
  logic              ta_reg;
  logic [AD_W-1:0]   ad_o_reg;
  logic [AD_W-1:0]   rd_data;
  logic [AD_W-1:0]   reg_q [NREG];
  logic              addr_hit;
  logic              commit;
  logic [3:0]        lane_en;

  assign addr_hit = ((FB_AD_I & BASE_MASK) == (FB_BASE & BASE_MASK));

  always_ff @(posedge FB_CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      idx_reg   <= '0;
      unmap_reg <= 1'b0;
      ta_reg    <= 1'b1;
      ad_o_reg  <= '0;
    end else begin
      ta_reg <= 1'b1;
      if (FB_ALE) begin
        // A new address phase overrides whatever transfer was in flight.
        if (addr_hit) begin
          state     <= ST_ADDR;
          idx_reg   <= FB_AD_I[7:2] & ~BASE_MASK[7:2];
          unmap_reg <= |(FB_AD_I[31:8] & ~BASE_MASK[31:8]);
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_ADDR: begin
            if (!FB_CS) begin
              ad_o_reg <= rd_data;
              if (WAIT_CYC == 0) begin
                state  <= ST_ACK;
                ta_reg <= 1'b0;
              end else begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_LOAD;
              end
            end
          end
          ST_WAIT: begin
            if (FB_CS) begin
              state <= ST_IDLE;
            end else if (wait_cnt == '0) begin
              state  <= ST_ACK;
              ta_reg <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          ST_ACK:  state <= ST_HOLD;
          ST_HOLD: if (FB_CS) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = UNMAP_RD_VAL;
    if (!unmap_reg) begin
      for (int k = 0; k < NREG; k++)
        if (idx_reg == IDX_W'(k)) rd_data = reg_q[k];
      for (int k = 0; k < NSTAT; k++)
        if ((NREG + k < 64) && (idx_reg == IDX_W'(NREG + k))) rd_data = STAT_Din[32*k +: 32];
    end
  end

  assign commit   = (state == ST_ACK) && !FB_RW && !FB_ALE && !unmap_reg;
  assign FB_TA    = ta_reg;
  assign FB_AD_O  = ad_o_reg;
  assign FB_AD_OE = ((state == ST_WAIT) || (state == ST_ACK) || (state == ST_HOLD)) && FB_RW && !FB_CS;

`ifdef FLEXBUS_BE_EN
  assign lane_en = ~FB_BE;
`else
  logic unused_be;
  assign unused_be = ^FB_BE;
  assign lane_en   = 4'hF;
`endif

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    flexbus_reg_slice #(
      .RST_VAL(REG_RST_VAL)
    ) u_slice (
      .clk     (FB_CLK),
      .rst     (RST),
      .we      (commit && (idx_reg == IDX_W'(gi))),
      .lane_en (lane_en),
      .wdata   (FB_AD_I),
      .q       (reg_q[gi]),
      .wstb    (REG_WSTB[gi])
    );
    assign REG_Qout[32*gi +: 32] = reg_q[gi];
  end

endmodule

// File: tb/tb_perip_flexbus_regfile.sv
// Scoreboard bench for perip_flexbus_regfile: random and directed FlexBus transfers vs. a register-array model.
module tb_perip_flexbus_regfile;
  localparam int          NREG  = 8;
  localparam int          NSTAT = 2;
  localparam int          WCYC  = 3;
  localparam logic [31:0] BASE  = 32'h6000_0000;
  localparam logic [31:0] MASK  = 32'hF000_0000;
  localparam logic [31:0] RSTV  = 32'h0;
  localparam logic [31:0] UNMAP = 32'hDEAD_BEEF;

  typedef logic [NREG*32-1:0] wide_t;

  logic              clk = 1'b0;
  logic              rst, ale, cs, rw;
  logic [3:0]        be;
  logic [31:0]       ad_i, ad_o;
  logic              oe, ta;
  wide_t             qout;
  logic [NREG-1:0]   wstb;
  logic [NSTAT*32-1:0] stat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit              is_rd;
    logic [31:0]     data;
    int              ta_cyc;
    logic [NREG-1:0] wstb;
    wide_t           qout;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model [NREG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  perip_flexbus_regfile #(
    .FB_BASE(BASE), .BASE_MASK(MASK), .NREG(NREG), .NSTAT(NSTAT),
    .WAIT_CYC(WCYC), .REG_RST_VAL(RSTV), .UNMAP_RD_VAL(UNMAP)
  ) dut (
    .FB_CLK(clk), .RST(rst), .FB_ALE(ale), .FB_CS(cs), .FB_RW(rw), .FB_BE(be),
    .FB_AD_I(ad_i), .FB_AD_O(ad_o), .FB_AD_OE(oe), .FB_TA(ta),
    .REG_Qout(qout), .REG_WSTB(wstb), .STAT_Din(stat)
  );

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic wide_t model_vec();
    wide_t v;
    for (int k = 0; k < NREG; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  // -1 = unmapped window offset; otherwise the register index
  function automatic int decode(input logic [31:0] addr);
    logic [31:0] off;
    off = addr & ~MASK;
    if ((off >> 8) != 0) return -1;
    return int'(off[7:2]);
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] b);
    logic [31:0] m;
`ifdef FLEXBUS_BE_EN
    for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'h00 : 8'hFF;
`else
    m = 32'hFFFF_FFFF;
`endif
    return m;
  endfunction

  task automatic do_txn(input logic [31:0] addr, input bit rd, input logic [31:0] wdata,
                        input logic [3:0] b, input bit b2b);
    exp_t        e;
    int          idx;
    bit          seen;
    logic [31:0] m;
    @(negedge clk);
    ale = 1'b1; ad_i = addr; cs = 1'b1; rw = rd; be = 4'hF;
    @(negedge clk);
    ale = 1'b0; cs = 1'b0; ad_i = rd ? $urandom : wdata; be = b;
    idx      = decode(addr);
    e.is_rd  = rd;
    e.ta_cyc = cyc + 1 + WCYC;
    e.wstb   = '0;
    e.data   = 32'h0;
    if (rd) begin
      if (idx < 0 || idx >= NREG + NSTAT) e.data = UNMAP;
      else if (idx < NREG)                e.data = model[idx];
      else                                e.data = stat[(idx-NREG)*32 +: 32];
    end else if (idx >= 0 && idx < NREG) begin
      m          = be_mask(b);
      model[idx] = (model[idx] & ~m) | (wdata & m);
      e.wstb[idx] = 1'b1;
    end
    e.qout = model_vec();
    expq.push_back(e);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) stat = {$urandom, $urandom};
      if (ta === 1'b0) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL ta_timeout addr=%08h act=no_ack exp=ack", addr);
      void'(expq.pop_back());
    end
    if (!b2b) begin
      @(negedge clk);
      cs = 1'b1;
    end
  endtask

  // Monitor: pops an expectation on every acknowledge, checks the following cycle too.
  initial begin
    exp_t e, pe;
    bit   pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("wstb", wide_t'(wstb), wide_t'(pe.wstb));
        chk("qout", qout, pe.qout);
        chk("ta_width", wide_t'(ta), wide_t'(1'b1));
        pend = 0;
      end else if (wstb !== '0) begin
        chk("spurious_wstb", wide_t'(wstb), wide_t'(0));
      end
      if (ta === 1'b0) begin
        if (expq.size() == 0) begin
          chk("spurious_ta", wide_t'(ta), wide_t'(1'b1));
        end else begin
          e = expq.pop_front();
          chk("ta_latency", wide_t'(cyc), wide_t'(e.ta_cyc));
          if (e.is_rd) begin
            chk("rdata", wide_t'(ad_o), wide_t'(e.data));
            chk("rd_oe", wide_t'(oe), wide_t'(1'b1));
          end
          pe   = e;
          pend = 1;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; ale = 1'b0; cs = 1'b1; rw = 1'b1; be = 4'hF; ad_i = '0;
    stat = {$urandom, $urandom};
    for (int k = 0; k < NREG; k++) model[k] = RSTV;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ta",   wide_t'(ta),   wide_t'(1'b1));
    chk("rst_oe",   wide_t'(oe),   wide_t'(1'b0));
    chk("rst_ad_o", wide_t'(ad_o), wide_t'(0));
    chk("rst_wstb", wide_t'(wstb), wide_t'(0));
    chk("rst_qout", qout, model_vec());

    for (int k = 0; k < NREG; k++) do_txn(BASE + 32'(k * 4), 1'b1, 32'h0, 4'hF, 1'b0);

    do_txn(32'h6000_0008, 1'b0, 32'hA5A5_1234, 4'h0, 1'b0);
    chk("reg2_write", wide_t'(qout[95:64]), wide_t'(32'hA5A5_1234));
    do_txn(32'h6000_0008, 1'b1, 32'h0, 4'hF, 1'b0);

    stat[31:0] = 32'hCAFE_F00D;
    do_txn(32'h6000_0020, 1'b1, 32'h0, 4'hF, 1'b0);
    do_txn(32'h6000_0024, 1'b1, 32'h0, 4'hF, 1'b0);

    // Address outside the window: no acknowledge, bus never driven.
    @(negedge clk);
    ale = 1'b1; ad_i = 32'h7000_0000; cs = 1'b1; rw = 1'b1;
    @(negedge clk);
    ale = 1'b0; cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("nomatch_ta_oe", wide_t'({ta, oe}), wide_t'(2'b10));
    end
    cs = 1'b1;

    do_txn(32'h6000_0100, 1'b0, 32'h1357_9BDF, 4'h0, 1'b0);
    do_txn(32'h6000_0100, 1'b1, 32'h0, 4'hF, 1'b0);
    do_txn(32'h6000_0028, 1'b1, 32'h0, 4'hF, 1'b0);

    do_txn(32'h6000_0000, 1'b0, 32'h0, 4'h0, 1'b0);
    do_txn(32'h6000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1010, 1'b0);
`ifdef FLEXBUS_BE_EN
    chk("be_reg0", wide_t'(qout[31:0]), wide_t'(32'h00FF_00FF));
`else
    chk("be_reg0", wide_t'(qout[31:0]), wide_t'(32'hFFFF_FFFF));
`endif

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) a = BASE + 32'($urandom_range(1, 255)) * 32'd256;
      else a = BASE + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             (n < 79) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset while a write sits in wait states: nothing commits.
    @(negedge clk);
    ale = 1'b1; ad_i = 32'h6000_000C; cs = 1'b1; rw = 1'b0;
    @(negedge clk);
    ale = 1'b0; cs = 1'b0; ad_i = 32'h1234_5678; be = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cs = 1'b1;
    for (int k = 0; k < NREG; k++) model[k] = RSTV;
    chk("midrst_qout", qout, model_vec());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_ta_wstb", wide_t'({ta, wstb}), wide_t'({1'b1, {NREG{1'b0}}}));
    end
    do_txn(32'h6000_000C, 1'b1, 32'h0, 4'hF, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_empty", wide_t'(expq.size()), wide_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
